// File: rtl/lsu_commit_arb.sv
// Merges per-block LSU commit streams into one ordered stream through a 2-entry FIFO.
// Multi-packet commits hold the grant (LOCKED) until their eop packet is accepted.
module lsu_commit_arb #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_BITS   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_eop,
  output logic [SRC_BITS-1:0]              out_src,
  input  logic                             out_ready,
  output logic                             dbg_state,
  output logic [SRC_BITS-1:0]              dbg_rr_ptr,
  output logic [SRC_BITS-1:0]              dbg_lock_idx,
  output logic [1:0]                       dbg_count
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Handshake: a beat moves on any port when its valid and ready are both high
  // at a rising clk edge; in_ready never looks at out_ready.

  arb_state_e              state_q, state_d;
  logic [SRC_BITS-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SRC_BITS-1:0]     lock_idx_q, lock_idx_d;
  logic [1:0]              count_q, count_d;
  logic                    head_q, head_d;
  logic [DATA_WIDTH-1:0]   mem_data_q [2];
  logic [DATA_WIDTH-1:0]   mem_data_d [2];
  logic [1:0]              mem_eop_q, mem_eop_d;
  logic [SRC_BITS-1:0]     mem_src_q [2];
  logic [SRC_BITS-1:0]     mem_src_d [2];

  logic                    grant_vld;
  logic [SRC_BITS-1:0]     grant_idx;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    grant_eop;
  logic                    grant_in_valid;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    wr_ptr;
  int                      scan_idx;

  // Scan from the highest offset down so the last hit is the nearest to rr_ptr.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
        scan_idx = (int'(rr_ptr_q) + k) % NUM_INPUTS;
        if (in_valid[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = SRC_BITS'(scan_idx);
        end
      end
    end
  end

  always_comb begin
    grant_data     = '0;
    grant_eop      = 1'b0;
    grant_in_valid = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx == SRC_BITS'(i)) begin
        grant_data     = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        grant_eop      = in_eop[i];
        grant_in_valid = in_valid[i];
      end
    end
  end

  // Full is taken from the registered count, so a pop cannot open a slot in the same cycle.
  assign fifo_full = (count_q == 2'd2);
  assign push      = grant_vld && grant_in_valid && !fifo_full && !reset;
  assign pop       = (count_q != 2'd0) && out_ready;
  assign wr_ptr    = head_q ^ count_q[0];

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      in_ready[i] = grant_vld && (grant_idx == SRC_BITS'(i)) && !fifo_full && !reset;
    end
  end

  assign out_valid    = (count_q != 2'd0);
  assign out_data     = mem_data_q[head_q];
  assign out_eop      = mem_eop_q[head_q];
  assign out_src      = mem_src_q[head_q];
  assign dbg_state    = state_q;
  assign dbg_rr_ptr   = rr_ptr_q;
  assign dbg_lock_idx = lock_idx_q;
  assign dbg_count    = count_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    count_d    = count_q;
    head_d     = head_q;
    mem_data_d = mem_data_q;
    mem_eop_d  = mem_eop_q;
    mem_src_d  = mem_src_q;

    if (pop) begin
      head_d = ~head_q;
    end

    if (push) begin
      mem_data_d[wr_ptr] = grant_data;
      mem_eop_d[wr_ptr]  = grant_eop;
      mem_src_d[wr_ptr]  = grant_idx;
      if (grant_eop) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == SRC_BITS'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = grant_idx;
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      lock_idx_q    <= '0;
      count_q       <= '0;
      head_q        <= 1'b0;
      mem_data_q[0] <= '0;
      mem_data_q[1] <= '0;
      mem_eop_q     <= '0;
      mem_src_q[0]  <= '0;
      mem_src_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      head_q     <= head_d;
      mem_data_q <= mem_data_d;
      mem_eop_q  <= mem_eop_d;
      mem_src_q  <= mem_src_d;
    end
  end

endmodule

// File: tb/tb_lsu_commit_arb.sv
// Directed and random stimulus for lsu_commit_arb, checked each cycle against a
// queue-based model of the arbitration rules.
module tb_lsu_commit_arb;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int SB = 1;
  localparam int EW = DW + 1 + SB;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_eop;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_eop;
  logic [SB-1:0]   out_src;
  logic            out_ready;
  logic            dbg_state;
  logic [SB-1:0]   dbg_rr_ptr;
  logic [SB-1:0]   dbg_lock_idx;
  logic [1:0]      dbg_count;

  lsu_commit_arb #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_eop(in_eop), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_eop(out_eop), .out_src(out_src),
    .out_ready(out_ready),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_lock_idx(dbg_lock_idx),
    .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected FIFO contents as {data, eop, src}, head at index 0.
  logic [EW-1:0] exp_q[$];
  bit            m_locked;
  int            m_rr;
  int            m_lock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v);
    if (m_locked) return m_lock;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_locked = 1'b0;
    m_rr     = 0;
    m_lock   = 0;
  endtask

  // One cycle: drive at the falling edge, check mid-low-phase, advance the model at the rising edge.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] e,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic ordy);
    int            g;
    bit            acc;
    bit            pp;
    logic [N-1:0]  exp_rdy;
    logic [EW-1:0] head;
    logic [DW-1:0] gd;
    in_valid  = v;
    in_eop    = e;
    in_data   = {d1, d0};
    out_ready = ordy;
    #1;
    g = model_grant(v);
    exp_rdy = '0;
    if (g >= 0 && exp_q.size() < 2) exp_rdy[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check("out_data", 64'(out_data), 64'(head[EW-1 -: DW]));
      check("out_eop", 64'(out_eop), 64'(head[SB]));
      check("out_src", 64'(out_src), 64'(head[SB-1:0]));
    end
    check("count", 64'(dbg_count), 64'(exp_q.size()));
    check("locked", 64'(dbg_state), 64'(m_locked));
    check("rr_ptr", 64'(dbg_rr_ptr), 64'(m_rr));
    check("lock_idx", 64'(dbg_lock_idx), 64'(m_lock));
    @(posedge clk);
    acc = (g >= 0) && v[g] && (exp_q.size() < 2);
    pp  = (exp_q.size() != 0) && ordy;
    if (pp) void'(exp_q.pop_front());
    if (acc) begin
      gd = (g == 0) ? d0 : d1;
      exp_q.push_back({gd, e[g], SB'(g)});
      if (e[g]) begin
        m_locked = 1'b0;
        m_rr     = (g + 1) % N;
      end else begin
        m_locked = 1'b1;
        m_lock   = g;
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset     = 1'b1;
    in_valid  = '1;
    in_eop    = '1;
    in_data   = '0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_out_eop", 64'(out_eop), 64'd0);
    check("rst_count", 64'(dbg_count), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = '0;

    // Single packet from block 0.
    step(2'b01, 2'b01, 64'hA5, 64'h0, 1'b1);
    check("single_rr_ptr", 64'(dbg_rr_ptr), 64'd1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'hA5);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    // Round-robin with both blocks always valid.
    for (int i = 0; i < 8; i++) step(2'b11, 2'b11, rnd64(), rnd64(), 1'b1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    // Three-packet commit from block 1 while block 0 waits.
    step(2'b10, 2'b00, 64'h0, 64'h1001, 1'b1);
    step(2'b11, 2'b01, 64'h0B0, 64'h1002, 1'b1);
    check("lock_blk0_ready", 64'(in_ready[0]), 64'd0);
    step(2'b11, 2'b11, 64'h0B0, 64'h1003, 1'b1);
    step(2'b01, 2'b01, 64'h0B0, 64'h0, 1'b1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    // Backpressure: output stalled for four cycles.
    for (int i = 0; i < 4; i++) step(2'b11, 2'b11, rnd64(), rnd64(), 1'b0);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(N'($urandom_range(0, 3)), N'($urandom_range(0, 3)), rnd64(), rnd64(),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    // Reset while locked on block 1 with a full FIFO.
    step(2'b10, 2'b00, 64'h0, rnd64(), 1'b0);
    step(2'b10, 2'b00, 64'h0, rnd64(), 1'b0);
    check("pre_rst_count", 64'(dbg_count), 64'd2);
    check("pre_rst_locked", 64'(dbg_state), 64'd1);
    in_valid = 2'b11;
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_count", 64'(dbg_count), 64'd0);
    check("async_locked", 64'(dbg_state), 64'd0);
    check("async_out_data", 64'(out_data), 64'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    step(2'b11, 2'b11, 64'hC0, 64'hC1, 1'b1);
    check("post_rst_src", 64'(out_src), 64'd0);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);
    step(2'b00, 2'b00, 64'h0, 64'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
